regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-port arbiter and sequencer for the core's `register_file`, which has a single write port (`we3`/`a3`/`wd3`). It shares that port between two writeback requesters: the ALU pipe and the memory/load unit. Each requester gets a one-entry holding buffer with valid/ready handshake, and the block preserves write order to a common destination. It also exports a pending-write mask that the issue logic uses for hazard checks.

## Interface
- `REGISTERS`, 32, number of architectural registers; register 0 is hard-wired zero.
- `WIDTH`, 32, data width.
- `AW`, `$clog2(REGISTERS)`, address width; derived, never overridden.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_ready`  out  1  ALU request accepted when `alu_valid && alu_ready` at a rising edge.
- `alu_rd`  in  AW  ALU destination register.
- `alu_data`  in  WIDTH  ALU result.
- `mem_valid`  in  1  load writeback request.
- `mem_ready`  out  1  same handshake rule as `alu_ready`.
- `mem_rd`  in  AW  load destination register.
- `mem_data`  in  WIDTH  load data.
- `we3`  out  1  register_file write enable, registered.
- `a3`  out  AW  register_file write address, registered.
- `wd3`  out  WIDTH  register_file write data, registered.
- `pend_mask`  out  REGISTERS  bit r=1 while a write to r is buffered or on the write port; bit 0 is always 0.

## Operation
- Each requester has a holding entry `{v, rd, data, age}`.
- `x_ready = !hold_x.v || grant_x`. The ready path is combinational from the hold state only and never depends on `x_valid`.
- A handshake with `rd == 0` is accepted and discarded. It never occupies the hold entry, never pulses `we3`, and never sets `pend_mask`.
- Age: an entry captured later is younger.
  - If both entries are captured on the same edge, mem is older.
  - An entry captured while the other is already occupied is younger.
- Grant, evaluated each cycle over occupied entries:
  - Only one occupied: grant it.
  - Both occupied with the same rd: grant the older, regardless of policy. This preserves last-writer-wins.
  - Both occupied with different rd: grant per policy (see Configuration).
- On a grant edge:
  - The output stage loads `we3=1`, `a3=rd`, `wd3=data`.
  - The granted hold entry clears, or reloads if the same requester handshakes in that cycle.
- No grant: `we3` loads 0. `a3`/`wd3` hold their last value.
- `pend_mask[r] = (hold_alu.v && hold_alu.rd==r) || (hold_mem.v && hold_mem.rd==r) || (we3 && a3==r)`.

## Timing
- Reset (async assert, sync release): both hold entries empty; `we3=0`, `a3=0`, `wd3=0`, `pend_mask=0`; `alu_ready=mem_ready=1`; round-robin pointer favours mem.
- Uncontended latency, for a handshake at edge k:
  - `we3=1` with the matching `a3`/`wd3` during cycle k+1..k+2.
  - register_file updated at edge k+2.
- `pend_mask[rd]` rises after edge k and falls after edge k+2.
- Sustained throughput: one write per cycle in total. A requester streaming alone sees `ready` held at 1.
- Contended: the loser's `ready=0` for each cycle its entry waits. The loser's data is never dropped or overwritten.
- Simultaneous handshakes on both ports with the same rd: `mem_data` is written first (edge k+2), then `alu_data` (edge k+3). The final register value is `alu_data`.
- Reset mid-operation: buffered writes are lost, `we3` drops to 0 immediately, and `pend_mask` clears immediately.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin between different-rd entries. A 1-bit pointer toggles to the non-granted side after every contended grant. Neither requester waits more than 1 cycle.
- Not defined: fixed priority, mem over alu. A continuously streaming mem port starves alu.
- The same-rd age rule applies in both builds.

## Test plan
- After reset, single ALU write rd=5, data 0xABCDE123 at edge k -> `we3=1`, `a3=5`, `wd3=0xABCDE123` after edge k+1; `pend_mask[5]` high for 2 cycles; register_file reg 5 reads 0xABCDE123.
- ALU rd=0, data 0x12345678 -> `alu_ready=1`, no `we3` pulse, `pend_mask==0`; reg 0 reads 0.
- Same-edge handshake, ALU rd=7/0x11111111 and mem rd=7/0x22222222 -> writes 0x22222222 then 0x11111111 on consecutive cycles; reg 7 ends at 0x11111111 in both builds.
- Both ports streaming 6 writes with distinct rd, without macro -> all mem writes first; `alu_ready=0` until mem stops; all 12 registers end correct.
- Both ports streaming 6 writes with distinct rd, with `WB_ARB_RR_EN` -> grants alternate mem/alu every cycle; each port's `ready` toggles 1/0; all 12 registers end correct.
- `rst_n` asserted while both entries are full -> same cycle: `we3=0`, `pend_mask=0`, both `ready=1`; no write to the register_file after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Shares the register_file write port between the ALU and load writeback paths.
// Define WB_ARB_RR_EN for round-robin between different-rd requests; default is fixed mem-over-alu priority.
module regfile_wb_arbiter #(
  parameter int REGISTERS = 32,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(REGISTERS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [AW-1:0]        alu_rd,
  input  logic [WIDTH-1:0]     alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [AW-1:0]        mem_rd,
  input  logic [WIDTH-1:0]     mem_data,
  output logic                 we3,
  output logic [AW-1:0]        a3,
  output logic [WIDTH-1:0]     wd3,
  output logic [REGISTERS-1:0] pend_mask
);

  logic             alu_v_p0;
  logic [AW-1:0]    alu_rd_p0;
  logic [WIDTH-1:0] alu_data_p0;
  logic             mem_v_p0;
  logic [AW-1:0]    mem_rd_p0;
  logic [WIDTH-1:0] mem_data_p0;
  logic             mem_older_p0;
  logic             mem_older_nxt;
  logic             grant_alu;
  logic             grant_mem;
  logic             alu_cap;
  logic             mem_cap;
  logic             both_v;
  logic             same_rd;

  assign both_v  = alu_v_p0 && mem_v_p0;
  assign same_rd = (alu_rd_p0 == mem_rd_p0);

`ifdef WB_ARB_RR_EN
  logic rr_mem_p0;

  // Pointer only moves on policy decisions; same-rd pairs are ordered by age instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_mem_p0 <= 1'b1;
    end else if (both_v && !same_rd) begin
      rr_mem_p0 <= grant_alu;
    end
  end
`endif

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (both_v) begin
      if (same_rd) begin
        grant_mem = mem_older_p0;
        grant_alu = !mem_older_p0;
      end else begin
`ifdef WB_ARB_RR_EN
        grant_mem = rr_mem_p0;
        grant_alu = !rr_mem_p0;
`else
        grant_mem = 1'b1;
`endif
      end
    end else begin
      grant_alu = alu_v_p0;
      grant_mem = mem_v_p0;
    end
  end

  assign alu_ready = !alu_v_p0 || grant_alu;
  assign mem_ready = !mem_v_p0 || grant_mem;

  // Writes to r0 complete the handshake but never reach the hold entries.
  assign alu_cap = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_cap = mem_valid && mem_ready && (mem_rd != '0);

  // A freshly captured alu entry is always the younger one, even when mem captures on the same edge.
  always_comb begin
    mem_older_nxt = mem_older_p0;
    if (alu_cap) begin
      mem_older_nxt = 1'b1;
    end else if (mem_cap) begin
      mem_older_nxt = 1'b0;
    end
  end

  // Stage p0: hold entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_v_p0     <= 1'b0;
      mem_v_p0     <= 1'b0;
      mem_older_p0 <= 1'b1;
    end else begin
      alu_v_p0     <= alu_cap || (alu_v_p0 && !grant_alu);
      mem_v_p0     <= mem_cap || (mem_v_p0 && !grant_mem);
      mem_older_p0 <= mem_older_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (alu_cap) begin
      alu_rd_p0   <= alu_rd;
      alu_data_p0 <= alu_data;
    end
    if (mem_cap) begin
      mem_rd_p0   <= mem_rd;
      mem_data_p0 <= mem_data;
    end
  end

  // Stage p1: register_file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= grant_alu || grant_mem;
      if (grant_mem) begin
        a3  <= mem_rd_p0;
        wd3 <= mem_data_p0;
      end else if (grant_alu) begin
        a3  <= alu_rd_p0;
        wd3 <= alu_data_p0;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int r = 1; r < REGISTERS; r++) begin
      pend_mask[r] = (alu_v_p0 && (alu_rd_p0 == AW'(r))) ||
                     (mem_v_p0 && (mem_rd_p0 == AW'(r))) ||
                     (we3 && (a3 == AW'(r)));
    end
  end

endmodule
